// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
//   NOP_INSTR        : canonical RV32I nop (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   DEFAULT_LAST_PC  : default last word address fetched
//   fetch_entry_t    : one prefetch buffer entry {pc, instr}
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_LAST_PC  = 32'd104;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk_i    : clock, all state on rising edge
//   rst_ni   : synchronous active-low reset
//   push_i   : write entry_i at the tail (ignored while flushing)
//   pop_i    : drop the head entry (ignored while empty)
//   flush_i  : discard all entries; wins over push, a coincident pop is discarded too
//   entry_i  : entry to write
//   head_o   : current head entry (meaningful only when !empty_o)
//   count_o  : number of stored entries
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               entry_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  fetch_entry_t mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthCnt);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed through count/empty.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator for a combinational-read, byte-addressed instruction memory.
// Fetches one word per cycle into a prefetch FIFO and hands {pc, instr} to decode.
//   clk            : clock, all state on rising edge
//   reset          : synchronous active-low reset
//   imem_pc        : fetch address to IMEM (the fetch PC register)
//   imem_instr     : IMEM read data for imem_pc, same cycle
//   redirect_valid : one-cycle branch/jump request, flushes buffered entries
//   redirect_pc    : redirect target
//   out_valid      : head entry valid
//   out_ready      : decode accepts the head entry
//   out_pc         : PC of head entry (0 when empty)
//   out_instr      : instruction of head entry (nop when empty)
//   fetch_done     : fetching stopped (end of program, out-of-range or misaligned target)
//   misalign_err   : sticky flag, a redirect target had pc[1:0] != 0
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] LAST_PC    = DEFAULT_LAST_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_done,
  output logic        misalign_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            done_q, done_d;
  logic            mis_q, mis_d;

  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  fetch_entry_t    fifo_head, fifo_in;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // Redirect owns the cycle: the fetched word belongs to the abandoned path.
  assign push      = !done_q && (!fifo_full || pop) && !redirect_valid;

  assign fifo_in.pc    = fetch_pc_q;
  assign fifo_in.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .entry_i (fifo_in),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    done_d     = done_q;
    mis_d      = mis_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        mis_d      = 1'b1;
        done_d     = 1'b1;
        fetch_pc_d = redirect_pc & ~32'd3;
      end else begin
        fetch_pc_d = redirect_pc;
        done_d     = (redirect_pc > LAST_PC);
      end
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      if (fetch_pc_q == LAST_PC) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_pc      = fetch_pc_q;
  assign fetch_done   = done_q;
  assign misalign_err = mis_q;
  assign out_pc       = fifo_empty ? 32'd0 : fifo_head.pc;
  assign out_instr    = fifo_empty ? NOP_INSTR : fifo_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-based reference model predicts the
// delivered {pc, instr} stream; a negedge monitor compares DUT outputs against it.
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0;
  localparam logic [31:0] LastPc  = 32'd104;
  localparam int          Depth   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        fetch_done, misalign_err;
  logic [31:0] imem_key;

  always #5 clk = ~clk;

  // IMEM contents: word = pc ^ key.
  assign imem_instr = imem_pc ^ imem_key;

  instr_fetch_unit #(
    .RESET_PC   (ResetPc),
    .LAST_PC    (LastPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_done     (fetch_done),
    .misalign_err   (misalign_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered entries, next fetch address, flags.
  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  bit           m_done, m_mis, m_rst_edge, started;

  always @(posedge clk) begin
    fetch_entry_t e;
    started    = 1'b1;
    m_rst_edge = !reset;
    if (!reset) begin
      exp_q.delete();
      m_pc   = ResetPc;
      m_done = 1'b0;
      m_mis  = 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
      if (redirect_pc[1:0] != 2'b00) begin
        m_mis  = 1'b1;
        m_done = 1'b1;
        m_pc   = {redirect_pc[31:2], 2'b00};
      end else begin
        m_pc   = redirect_pc;
        m_done = (redirect_pc > LastPc);
      end
    end else if (!m_done && exp_q.size() < Depth) begin
      // The monitor has already removed an entry popped at this edge.
      e.pc    = m_pc;
      e.instr = m_pc ^ imem_key;
      exp_q.push_back(e);
      if (m_pc == LastPc) m_done = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  end

  // Monitor: compares mid-cycle and retires the head when a handshake will complete.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("imem_pc", imem_pc, m_pc);
      chk("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      if (m_rst_edge) begin
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, NOP_INSTR);
      end
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
        if (out_ready && reset) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int r;
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_key       = '0;

    // Reset state and streaming
    step(); step();
    chk("rst_imem_pc", imem_pc, ResetPc);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    step();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("stream_pc0", out_pc, 32'd0);
    step(); chk("stream_pc4", out_pc, 32'd4);
    step(); chk("stream_pc8", out_pc, 32'd8);
    step(); chk("stream_instr12", out_instr, 32'd12);

    // Backpressure
    reset = 1'b0; step();
    reset = 1'b1; out_ready = 1'b0;
    step();
    repeat (5) step();
    chk("bp_imem_pc", imem_pc, 32'd8);
    chk("bp_out_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    step(); chk("bp_resume4", out_pc, 32'd4);
    step(); chk("bp_resume8", out_pc, 32'd8);
    step(); chk("bp_resume12", out_pc, 32'd12);

    // Redirect with full FIFO
    out_ready = 1'b0;
    reset = 1'b0; step();
    reset = 1'b1; step(); step();
    redirect(32'h40);
    chk("redir_flush", {31'd0, out_valid}, 32'd0);
    step(); chk("redir_pc40", out_pc, 32'h40);
    out_ready = 1'b1;
    step(); chk("redir_pc44", out_pc, 32'h44);

    // Misaligned redirect, then aligned resume
    redirect(32'h42);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_done", {31'd0, fetch_done}, 32'd1);
    step(); step();
    chk("mis_idle", {31'd0, out_valid}, 32'd0);
    redirect(32'h10);
    step();
    chk("mis_resume_pc", out_pc, 32'h10);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // End of program
    reset = 1'b0; step();
    reset = 1'b1; out_ready = 1'b1;
    repeat (27) step();
    chk("eop_last_pc", out_pc, LastPc);
    chk("eop_done", {31'd0, fetch_done}, 32'd1);
    step();
    chk("eop_empty", {31'd0, out_valid}, 32'd0);
    repeat (4) step();
    chk("eop_imem_pc", imem_pc, 32'd108);

    // Reset mid-run with FIFO full and misalign set
    redirect(32'h3);
    out_ready = 1'b0;
    redirect(32'h0);
    step(); step();
    reset = 1'b0; step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("mid_rst_pc", imem_pc, ResetPc);
    reset = 1'b1; step();
    chk("mid_rst_restart", out_pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 250) != 0;
      if (!reset) imem_key = $urandom;
      r = $urandom % 100;
      redirect_valid = (r < 6);
      case ($urandom % 4)
        0:       redirect_pc = 32'($urandom_range(0, 26)) * 4;
        1:       redirect_pc = 32'($urandom_range(0, 26)) * 4;
        2:       redirect_pc = 32'd108 + 32'($urandom_range(0, 15)) * 4;
        default: redirect_pc = 32'($urandom_range(0, 30)) * 4 + 32'($urandom_range(1, 3));
      endcase
      step();
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the byte-addressed, little-endian, combinational-read instruction memory.
- Drives the fetch PC, captures the returned 32-bit instruction word, and buffers {pc, instr} pairs in a small prefetch FIFO.
- Presents entries to decode over a valid/ready handshake.
- Handles redirects (branch/jump), misaligned targets and end-of-program.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- LAST_PC, 32'd104, last word address the unit fetches; the word at 104 covers bytes 104..107.
- FIFO_DEPTH, 2, prefetch entries; must be a power of two, 2 or more.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; state is reset at any posedge where reset==0
- imem_pc  out  32  fetch address to IMEM; equals internal fetch_pc register
- imem_instr  in  32  IMEM read data, combinational from imem_pc, same cycle
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  32  redirect target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- fetch_done  out  1  fetching stopped (end of program or misalign)
- misalign_err  out  1  sticky; redirect target had pc[1:0]!=0

Behaviour:
Reset values:
- fetch_pc=imem_pc=RESET_PC; FIFO empty; out_valid=0.
- out_pc=0, out_instr=32'h00000013.
- fetch_done=0, misalign_err=0.
- A reset asserted mid-operation discards all entries; no handshake completes in that cycle.

Push (per cycle):
- push = !fetch_done && (count<FIFO_DEPTH || pop) && !redirect_valid.
- On push: write {fetch_pc, imem_instr} to the tail; fetch_pc += 4.
- A push of fetch_pc==LAST_PC also sets fetch_done=1 and leaves fetch_pc at LAST_PC+4.

Pop:
- pop = out_valid && out_ready.
- out_valid = (count!=0).
- out_pc and out_instr come from the FIFO head and are held stable while out_valid && !out_ready.

Latency and throughput:
- An instruction fetched at posedge N is visible on out_* after posedge N, i.e. one cycle.
- The first out_valid appears one cycle after the first posedge with reset==1.
- Sustained throughput is 1 instruction/cycle with out_ready=1.

Full FIFO:
- Simultaneous push and pop is allowed; count is unchanged.
- When full and no pop: imem_pc holds, nothing is lost or duplicated.

Redirect (priority over push; below reset):
- A pop completing in the redirect cycle still counts as consumed.
- All remaining entries are flushed; count=0 next cycle.
- No push occurs in the redirect cycle.
- If redirect_pc[1:0]==0 and redirect_pc<=LAST_PC: fetch_pc<=redirect_pc, fetch_done<=0.
- If redirect_pc[1:0]==0 and redirect_pc>LAST_PC: fetch_pc<=redirect_pc, fetch_done<=1, nothing pushed.
- If redirect_pc[1:0]!=0: misalign_err<=1 (sticky until reset), fetch_done<=1, fetch_pc<=redirect_pc & ~3.
- A later aligned redirect resumes fetching; misalign_err stays set.

Width rules:
- fetch_pc is 32-bit and wraps modulo 2^32; this is unreachable in practice because fetch stops at LAST_PC.
- FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap.
- count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package rv_fetch_pkg holds:
  - NOP_INSTR=32'h00000013
  - default RESET_PC and LAST_PC
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with parameter DEPTH.
  - Inputs: push, pop, flush. Outputs: head, count, full, empty.
  - flush has priority over push. A pop coincident with flush is legal and discards.
- The FSM-free control (push/pop/redirect/done logic) stays in instr_fetch_unit.

Test Plan:
- Streaming: hold reset=0 for 2 cycles, then 1; out_ready=1; IMEM model loaded with word=pc. Expect out_valid from cycle 1, out_pc 0,4,8,12 on consecutive cycles, out_instr==out_pc.
- Backpressure: out_ready=0 for 5 cycles after the first valid. Expect count saturates at 2, imem_pc held at 8, out_pc held at 0. Then set out_ready=1 and expect out_pc 0,4,8,12 with no gap or duplicate.
- Redirect with full FIFO: while entries 0 and 4 are buffered, redirect_valid=1, redirect_pc=0x40, out_ready=0. Next cycle out_valid=0. The cycle after, out_pc=0x40, followed by 0x44; 0 and 4 are never delivered.
- Misaligned redirect: redirect_pc=0x42. Expect misalign_err=1 and fetch_done=1 next cycle, out_valid=0 thereafter. Then a redirect to 0x10 gives out_pc=0x10 while misalign_err stays 1.
- End of program: stream from 0 with out_ready=1. Expect the last out_pc=104, fetch_done=1 after the push of 104, and out_valid=0 after 104 is popped. imem_pc stays at 108 and is never pushed.
- Reset mid-run: with the FIFO full, drive reset=0 for one cycle. Expect out_valid=0, fetch_done=0, misalign_err=0, imem_pc=RESET_PC, then a clean restart at out_pc=0.
